add_share_arbiter: RTL and testbench

//   Shares one registered WIDTH-bit adder among NUM_REQ requesters.

---
 rtl/add_share_arbiter_pkg.sv | 16 +
 rtl/add_share_arbiter_rr_arbiter.sv | 31 +++
 rtl/add_share_arbiter.sv | 114 +++++++++++
 tb/tb_add_share_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_share_arbiter_pkg.sv
// Shared types and helpers for the shared-adder arbiter: FSM state encoding
// and the requester-ID width calculation.
package add_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/add_share_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping
// from N-1 back to 0, and reports the first asserted requester.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic          found;
   logic [IW-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/add_share_arbiter.sv
// Shares one registered adder among NUM_REQ requesters: round-robin grant in
// IDLE, one add cycle in EXEC, tagged result held in RESP until accepted.
module add_share_arbiter
   import add_share_pkg::*;
#(
   parameter  int WIDTH   = 40,
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic                     resp_valid,
   input  logic                     resp_ready,
   output logic [ID_W-1:0]          resp_id,
   output logic [WIDTH-1:0]         resp_sum,
   output logic                     resp_carry,
   output logic                     busy
);

   state_t             state, state_nxt;
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    op_id;
   logic [WIDTH-1:0]   op_a, op_b;
   logic               accept;
   logic               resp_done;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Grants are only offered in IDLE and never while reset is held, so the
   // one-hot arbiter result doubles as the accept strobe.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      resp_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (rst) begin
               req_ready = grant;
               if (|grant) begin
                  accept    = 1'b1;
                  state_nxt = EXEC;
               end
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            if (resp_ready) begin
               resp_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Only the winner's operands are captured; the pointer moves just past it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr <= '0;
         op_id  <= '0;
         op_a   <= '0;
         op_b   <= '0;
      end else if (accept) begin
         rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
         op_id  <= grant_idx;
         op_a   <= req_a[int'(grant_idx) * WIDTH +: WIDTH];
         op_b   <= req_b[int'(grant_idx) * WIDTH +: WIDTH];
      end
   end

   // Result registers load once in EXEC and then hold through any backpressure.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_sum   <= '0;
         resp_carry <= 1'b0;
      end else if (state == EXEC) begin
         resp_valid              <= 1'b1;
         resp_id                 <= op_id;
         {resp_carry, resp_sum}  <= {1'b0, op_a} + {1'b0, op_b};
      end else if (resp_done) begin
         resp_valid <= 1'b0;
      end
   end

   assign busy = (state != IDLE);

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst)
      $onehot0(req_ready));
   a_ready_idle_only: assert property (@(posedge clk) disable iff (!rst)
      (state != IDLE) |-> (req_ready == '0));

endmodule

// File: tb/tb_add_share_arbiter.sv
// Directed bench for add_share_arbiter with a transaction-level reference
// model checked on every falling edge.
module tb_add_share_arbiter;

   localparam int W = 40;
   localparam int N = 4;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a, req_b;
   logic           resp_valid;
   logic           resp_ready;
   logic [1:0]     resp_id;
   logic [W-1:0]   resp_sum;
   logic           resp_carry;
   logic           busy;

   logic [W-1:0]   a_arr [N];
   logic [W-1:0]   b_arr [N];

   int n_cmp  = 0;
   int n_fail = 0;

   assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
   assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

   add_share_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_sum   (resp_sum),
      .resp_carry (resp_carry),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: one outstanding transaction, result due two samples
   // after the grant sample, pointer one past the last winner.
   int          m_ptr = 0;
   int          m_id  = 0;
   int          m_cyc = 0;
   int          m_due = 0;
   int          m_win;
   bit          m_out = 1'b0;
   logic [63:0] m_total;
   logic [3:0]  m_grant;

   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("mdl_rst_ready", 64'(req_ready), 64'd0);
         checkOutput("mdl_rst_valid", 64'(resp_valid), 64'd0);
         checkOutput("mdl_rst_busy", 64'(busy), 64'd0);
         m_out = 1'b0;
         m_ptr = 0;
      end else if (!m_out) begin
         m_win = -1;
         for (int k = 0; k < N; k++)
            if (m_win < 0 && req_valid[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
         m_grant = (m_win < 0) ? 4'd0 : 4'(1 << m_win);
         checkOutput("mdl_ready", 64'(req_ready), 64'(m_grant));
         checkOutput("mdl_idle_valid", 64'(resp_valid), 64'd0);
         checkOutput("mdl_idle_busy", 64'(busy), 64'd0);
         if (m_win >= 0) begin
            m_out   = 1'b1;
            m_id    = m_win;
            m_total = 64'(a_arr[m_win]) + 64'(b_arr[m_win]);
            m_due   = m_cyc + 2;
            m_ptr   = (m_win + 1) % N;
         end
      end else if (m_cyc < m_due) begin
         checkOutput("mdl_exec_ready", 64'(req_ready), 64'd0);
         checkOutput("mdl_exec_valid", 64'(resp_valid), 64'd0);
         checkOutput("mdl_exec_busy", 64'(busy), 64'd1);
      end else begin
         checkOutput("mdl_resp_ready", 64'(req_ready), 64'd0);
         checkOutput("mdl_resp_valid", 64'(resp_valid), 64'd1);
         checkOutput("mdl_resp_busy", 64'(busy), 64'd1);
         checkOutput("mdl_resp_id", 64'(resp_id), 64'(m_id));
         checkOutput("mdl_resp_sum", 64'(resp_sum), m_total & 64'hFF_FFFF_FFFF);
         checkOutput("mdl_resp_carry", 64'(resp_carry), (m_total >> 40) & 64'd1);
         if (resp_ready) m_out = 1'b0;
      end
      m_cyc++;
   end

   // One full operation with resp_ready high; expectations are literals.
   task automatic applyStimulus(input logic [3:0] valid, input int exp_id,
                                input logic [W-1:0] exp_sum, input logic exp_carry,
                                input string tag, input bit hold);
      int waited;
      req_valid  = valid;
      resp_ready = 1'b1;
      waited     = 0;
      @(negedge clk);
      while (req_ready == '0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({tag, "_grant"}, 64'(req_ready), 64'd1 << exp_id);
      @(posedge clk); #1;
      if (!hold) req_valid = '0;
      waited = 0;
      @(negedge clk);
      while (!resp_valid && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({tag, "_lat"}, 64'(waited), 64'd1);
      checkOutput({tag, "_id"}, 64'(resp_id), 64'(exp_id));
      checkOutput({tag, "_sum"}, 64'(resp_sum), 64'(exp_sum));
      checkOutput({tag, "_carry"}, 64'(resp_carry), 64'(exp_carry));
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst        = 1'b0;
      req_valid  = '0;
      resp_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
         a_arr[i] = '0;
         b_arr[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_sum", 64'(resp_sum), 64'd0);
      checkOutput("rst_id", 64'(resp_id), 64'd0);
      rst = 1'b1;

      $display("[TB] single request");
      a_arr[2] = 40'd5;
      b_arr[2] = 40'd7;
      applyStimulus(4'b0100, 2, 40'd12, 1'b0, "t1", 1'b0);

      $display("[TB] carry and wrap");
      a_arr[3] = 40'hFF_FFFF_FFFF;
      b_arr[3] = 40'h1;
      applyStimulus(4'b1000, 3, 40'd0, 1'b1, "t2a", 1'b0);
      a_arr[0] = 40'h80_0000_0000;
      b_arr[0] = 40'h80_0000_0000;
      applyStimulus(4'b0001, 0, 40'd0, 1'b1, "t2b", 1'b0);

      $display("[TB] backpressure");
      a_arr[1] = 40'd11;
      b_arr[1] = 40'd22;
      a_arr[2] = 40'd1000;
      b_arr[2] = 40'd24;
      req_valid  = 4'b0110;
      resp_ready = 1'b0;
      @(negedge clk);
      checkOutput("t4_grant", 64'(req_ready), 64'h2);
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         req_valid[3] = i[0];
         @(negedge clk);
         checkOutput("t4_hold_valid", 64'(resp_valid), 64'd1);
         checkOutput("t4_hold_sum", 64'(resp_sum), 64'd33);
         checkOutput("t4_hold_ready", 64'(req_ready), 64'd0);
         @(posedge clk); #1;
      end
      req_valid  = 4'b0110;
      resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("t4_last_id", 64'(resp_id), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("t4_idle_busy", 64'(busy), 64'd0);
      checkOutput("t4_next_grant", 64'(req_ready), 64'h4);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("t4_second_sum", 64'(resp_sum), 64'd1024);
      @(posedge clk); #1;
      a_arr[0] = 40'd7;
      b_arr[0] = 40'd8;
      applyStimulus(4'b0011, 0, 40'd15, 1'b0, "t4_wrap", 1'b0);

      $display("[TB] reset mid-operation");
      a_arr[1] = 40'h12_3456_789A;
      b_arr[1] = 40'h1;
      req_valid  = 4'b0010;
      resp_ready = 1'b1;
      @(negedge clk);
      checkOutput("t5_grant", 64'(req_ready), 64'h2);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      checkOutput("t5_busy", 64'(busy), 64'd0);
      checkOutput("t5_valid", 64'(resp_valid), 64'd0);
      checkOutput("t5_ready", 64'(req_ready), 64'd0);
      checkOutput("t5_sum", 64'(resp_sum), 64'd0);
      checkOutput("t5_id", 64'(resp_id), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst       = 1'b1;
      req_valid = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("t5_no_resp", 64'(resp_valid), 64'd0);
      end
      @(posedge clk); #1;

      $display("[TB] fairness");
      for (int i = 0; i < N; i++) begin
         a_arr[i] = 40'(100 * (i + 1));
         b_arr[i] = 40'(i + 1);
      end
      applyStimulus(4'b1111, 0, 40'd101, 1'b0, "f0", 1'b1);
      applyStimulus(4'b1111, 1, 40'd202, 1'b0, "f1", 1'b1);
      applyStimulus(4'b1111, 2, 40'd303, 1'b0, "f2", 1'b1);
      applyStimulus(4'b1111, 3, 40'd404, 1'b0, "f3", 1'b1);
      applyStimulus(4'b1111, 0, 40'd101, 1'b0, "f4", 1'b0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
